// File: rtl/prog_loader_mem_pkg.sv
// Shared definitions for the program loader / program memory.
//   state_t    : loader FSM states (length header, data bytes, done)
//   INSN_ZERO  : instruction word presented to the CPU while held or out of range
package prog_loader_mem_pkg;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [15:0] INSN_ZERO = 16'h0000;

endpackage

// File: rtl/prog_loader_mem_ram.sv
// prog_ram: 2^ADDR_W x 16 program storage. No reset on the array.
//   clk   : write clock
//   we    : write enable (synchronous)
//   waddr : write word address
//   wdata : write word
//   raddr : read word address (asynchronous read)
//   rdata : read word
module prog_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader_mem.sv
// Program memory plus length-prefixed byte-stream loader for the stack CPU.
// Bytes are packed big-endian into 16-bit words written from word 0 upward;
// the CPU is held until the load finishes.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_data    : loader byte; rx_valid / rx_ready handshake
//   reload     : start a new load (honoured only in DONE)
//   cpu_addr   : CPU word address; cpu_data : instruction word (0 while held)
//   cpu_hold   : CPU stall while loading; load_done : high in DONE
//   load_err   : sticky, declared length exceeded the memory depth
module prog_loader_mem
  import prog_loader_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [15:0] cpu_addr,
  output logic [15:0] cpu_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic        err_q, err_d;
  logic        we;
  logic        xfer;
  logic [15:0] rd_data;
  logic [15:0] addr_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LEN_HI;
      len_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  assign xfer = rx_valid && rx_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      LEN_HI: if (xfer) begin
        len_d[15:8] = rx_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        len_d[7:0] = rx_data;
        cnt_d      = '0;
        if ({1'b0, len_q[15:8], rx_data} > DEPTH) err_d = 1'b1;
        state_d = ({len_q[15:8], rx_data} == 16'd0) ? DONE : DATA_HI;
      end
      DATA_HI: if (xfer) begin
        hi_d    = rx_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (xfer) begin
        cnt_d = cnt_q + 16'd1;
        // words beyond the array are consumed but never written
        we      = ({1'b0, cnt_q} < DEPTH);
        state_d = (cnt_q + 16'd1 == len_q) ? DONE : DATA_HI;
      end
      DONE: if (reload) begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = LEN_HI;
      end
      default: state_d = LEN_HI;
    endcase
  end

  prog_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (cnt_q[ADDR_W-1:0]),
    .wdata ({hi_q, rx_data}),
    .raddr (cpu_addr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  assign addr_hi   = cpu_addr >> ADDR_W;
  assign rx_ready  = (state_q != DONE);
  assign cpu_hold  = (state_q != DONE);
  assign load_done = (state_q == DONE);
  assign load_err  = err_q;
  assign cpu_data  = (cpu_hold || (addr_hi != 16'd0)) ? INSN_ZERO : rd_data;

endmodule

// File: tb/tb_prog_loader_mem.sv
// Two loaders (8-bit and 2-bit word address) fed the same byte streams and
// compared against a stream-level model of the expected memory image.
module tb_prog_loader_mem;

  localparam int unsigned DA = 256;
  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        reload = 1'b0;
  logic [15:0] cpu_addr = '0;

  logic        a_rx_ready, a_cpu_hold, a_load_done, a_load_err;
  logic [15:0] a_cpu_data;
  logic        b_rx_ready, b_cpu_hold, b_load_done, b_load_err;
  logic [15:0] b_cpu_data;

  always #5 clk = ~clk;

  prog_loader_mem #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(a_rx_ready), .reload(reload), .cpu_addr(cpu_addr),
    .cpu_data(a_cpu_data), .cpu_hold(a_cpu_hold), .load_done(a_load_done),
    .load_err(a_load_err)
  );

  prog_loader_mem #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(b_rx_ready), .reload(reload), .cpu_addr(cpu_addr),
    .cpu_data(b_cpu_data), .cpu_hold(b_cpu_hold), .load_done(b_load_done),
    .load_err(b_load_err)
  );

  int checks = 0;
  int errors = 0;

  // stream-level model
  logic [15:0] ref_a [DA];
  bit          known_a [DA];
  logic [15:0] ref_b [DB];
  bit          known_b [DB];
  bit          err_a, err_b, mdone;
  int unsigned pos, mlen;
  logic [7:0]  lenhi, mhi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_ctrl();
    pos = 0; mlen = 0; mdone = 0; err_a = 0; err_b = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int unsigned w;
    if (pos == 0) lenhi = b;
    else if (pos == 1) begin
      mlen = {lenhi, b};
      if (mlen > DA) err_a = 1;
      if (mlen > DB) err_b = 1;
    end else if (pos % 2 == 0) mhi = b;
    else begin
      w = (pos - 2) / 2;
      if (w < DA) begin ref_a[w] = {mhi, b}; known_a[w] = 1; end
      if (w < DB) begin ref_b[w] = {mhi, b}; known_b[w] = 1; end
    end
    pos++;
    mdone = (pos >= 2) && (pos == 2 + 2 * mlen);
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".a_ready"}, a_rx_ready, !mdone);
    chk({tag, ".b_ready"}, b_rx_ready, !mdone);
    chk({tag, ".a_hold"}, a_cpu_hold, !mdone);
    chk({tag, ".b_hold"}, b_cpu_hold, !mdone);
    chk({tag, ".a_done"}, a_load_done, mdone);
    chk({tag, ".b_done"}, b_load_done, mdone);
    chk({tag, ".a_err"}, a_load_err, err_a);
    chk({tag, ".b_err"}, b_load_err, err_b);
    if (!mdone) begin
      cpu_addr = 16'($urandom_range(0, 3));
      #1;
      chk({tag, ".a_held_data"}, a_cpu_data, 16'h0000);
      chk({tag, ".b_held_data"}, b_cpu_data, 16'h0000);
    end
  endtask

  // one byte transfer, preceded by up to maxgap idle cycles
  task automatic send(input logic [7:0] b, input int unsigned maxgap);
    int unsigned gaps;
    gaps = $urandom_range(0, maxgap);
    repeat (gaps) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
      check_status("stall");
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    model_byte(b);
    check_status("xfer");
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    if (mdone) begin pos = 0; mlen = 0; mdone = 0; err_a = 0; err_b = 0; end
    check_status(tag);
  endtask

  task automatic check_mem(input string tag);
    for (int unsigned i = 0; i < DA; i++) begin
      if (known_a[i]) begin
        cpu_addr = 16'(i); #1;
        chk({tag, ".a_mem"}, a_cpu_data, ref_a[i]);
      end
    end
    for (int unsigned i = 0; i < DB; i++) begin
      if (known_b[i]) begin
        cpu_addr = 16'(i); #1;
        chk({tag, ".b_mem"}, b_cpu_data, ref_b[i]);
      end
    end
    cpu_addr = 16'h0100; #1;
    chk({tag, ".a_oor"}, a_cpu_data, 16'h0000);
    cpu_addr = 16'h0004; #1;
    chk({tag, ".b_oor"}, b_cpu_data, 16'h0000);
  endtask

  task automatic send_stream(input logic [7:0] s [$], input int unsigned maxgap);
    foreach (s[i]) send(s[i], maxgap);
  endtask

  initial begin
    logic [7:0] s [$];
    int unsigned n;
    for (int unsigned i = 0; i < DA; i++) known_a[i] = 0;
    for (int unsigned i = 0; i < DB; i++) known_b[i] = 0;
    model_clear_ctrl();

    // reset state
    #1;
    check_status("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_status("post_reset");

    // basic two-word load, back-to-back bytes
    s = '{8'h00, 8'h02, 8'h80, 8'h05, 8'h03, 8'h00};
    send_stream(s, 0);
    chk("basic_done", {31'd0, mdone}, 32'd1);
    cpu_addr = 16'h0001; #1;
    chk("basic_word1", a_cpu_data, 16'h0300);
    check_mem("basic");

    // zero-length load
    do_reload("reload1");
    s = '{8'h00, 8'h00};
    send_stream(s, 0);
    chk("zero_done", a_load_done, 1'b1);
    check_mem("zero");

    // declared length beyond the small memory's depth
    do_reload("reload2");
    s = '{8'h00, 8'h05};
    for (int unsigned i = 0; i < 10; i++) s.push_back(8'($urandom));
    send_stream(s, 0);
    chk("ovf_err", b_load_err, 1'b1);
    check_mem("ovf");

    // same two-word load with idle gaps, plus a reload pulse mid-load that must be ignored
    do_reload("reload3");
    send(8'h00, 3);
    do_reload("ignored_reload");
    s = '{8'h02, 8'h80, 8'h05, 8'h03, 8'h00};
    send_stream(s, 3);
    check_mem("gappy");

    // one-word reload leaves word 1 intact
    do_reload("reload4");
    s = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_stream(s, 0);
    cpu_addr = 16'h0000; #1;
    chk("reload_word0", a_cpu_data, 16'h1234);
    cpu_addr = 16'h0001; #1;
    chk("reload_word1", a_cpu_data, 16'h0300);
    check_mem("reload");

    // random loads
    repeat (4) begin
      do_reload("reload_rand");
      n = $urandom_range(1, 7);
      s = '{8'h00, 8'(n)};
      for (int unsigned i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
      send_stream(s, 2);
      check_mem("rand");
    end

    // reset in the middle of the data phase
    do_reload("reload5");
    s = '{8'h00, 8'h03, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
    send_stream(s, 0);
    #2 rst_n = 1'b0;
    model_clear_ctrl();
    #1;
    check_status("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    s = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_stream(s, 1);
    cpu_addr = 16'h0001; #1;
    chk("after_reset_word1", a_cpu_data, 16'hccdd);
    check_mem("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
